// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle RV32M MUL/DIV/REM sequencer that borrows the 5-bit-coded ALU per iteration.
// Optional macro MULDIV_ALU_SHARE_EN adds alu_grant; an ITER step then commits only when granted.
module alu_muldiv_seq #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ITER_CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [XLEN-1:0]       rs1,
  input  logic [XLEN-1:0]       rs2,
  input  logic [XLEN-1:0]       alu_out,
`ifdef MULDIV_ALU_SHARE_EN
  input  logic                  alu_grant,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [XLEN-1:0]       result,
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  output logic [4:0]            alu_ctl
);

  localparam int unsigned PROD_W = 2 * XLEN;
  localparam int unsigned CTL_W  = 5;

  localparam logic [CTL_W-1:0] ALU_ADD = 5'b00001;
  localparam logic [CTL_W-1:0] ALU_SUB = 5'b01001;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t                  state, state_n;
  logic [2:0]              op_q, op_n;
  logic [XLEN-1:0]         rs1_q, rs1_n, rs2_q, rs2_n;
  logic [XLEN-1:0]         opnd_q, opnd_n;
  logic [XLEN-1:0]         acc_hi, hi_n, acc_lo, lo_n;
  logic                    neg_res, neg_n;
  logic [ITER_CNT_W-1:0]   cnt, cnt_n;
  logic [XLEN-1:0]         result_n, alu_a_n, alu_b_n;
  logic [CTL_W-1:0]        alu_ctl_n;
  logic                    busy_n, done_n;

  logic                    step_en;
  logic                    is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]         a_abs, b_abs;
  logic                    carry, take;
  logic [XLEN:0]           shifted;
  logic [PROD_W-1:0]       prod, prod_fix;
  logic [XLEN-1:0]         div_val;

`ifdef MULDIV_ALU_SHARE_EN
  assign step_en = alu_grant;
`else
  assign step_en = 1'b1;
`endif

  // Operand sign conditioning from the latched request
  assign is_div   = op_q[2];
  assign a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
  assign b_signed = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
  assign a_neg    = a_signed & rs1_q[XLEN-1];
  assign b_neg    = b_signed & rs2_q[XLEN-1];
  assign a_abs    = a_neg ? (XLEN'(0) - rs1_q) : rs1_q;
  assign b_abs    = b_neg ? (XLEN'(0) - rs2_q) : rs2_q;

  // Per-iteration datapath terms; alu_out reflects the registered alu_a/alu_b
  assign carry    = (alu_out < acc_hi);
  assign shifted  = {acc_hi, acc_lo[XLEN-1]};
  assign take     = shifted[XLEN] | (shifted[XLEN-1:0] >= opnd_q);
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_res ? (PROD_W'(0) - prod) : prod;
  assign div_val  = op_q[1] ? acc_hi : acc_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      opnd_q  <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      neg_res <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_ctl <= ALU_ADD;
    end else begin
      state   <= state_n;
      op_q    <= op_n;
      rs1_q   <= rs1_n;
      rs2_q   <= rs2_n;
      opnd_q  <= opnd_n;
      acc_hi  <= hi_n;
      acc_lo  <= lo_n;
      neg_res <= neg_n;
      cnt     <= cnt_n;
      result  <= result_n;
      busy    <= busy_n;
      done    <= done_n;
      alu_a   <= alu_a_n;
      alu_b   <= alu_b_n;
      alu_ctl <= alu_ctl_n;
    end
  end

  always_comb begin
    state_n   = state;
    op_n      = op_q;
    rs1_n     = rs1_q;
    rs2_n     = rs2_q;
    opnd_n    = opnd_q;
    hi_n      = acc_hi;
    lo_n      = acc_lo;
    neg_n     = neg_res;
    cnt_n     = cnt;
    result_n  = result;
    alu_a_n   = '0;
    alu_b_n   = '0;
    alu_ctl_n = ALU_ADD;

    unique case (state)
      IDLE: begin
        if (start) begin
          op_n    = op;
          rs1_n   = rs1;
          rs2_n   = rs2;
          state_n = PREP;
        end
      end
      PREP: begin
        neg_n = (op_q == OP_REM) ? a_neg : (a_neg ^ b_neg);
        hi_n  = '0;
        cnt_n = ITER_CNT_W'(XLEN);
        if (is_div) begin
          opnd_n = b_abs;
          lo_n   = a_abs;
          if (rs2_q == '0) begin
            // Divide by zero: quotient all ones, remainder is the raw dividend
            result_n = op_q[1] ? rs1_q : {XLEN{1'b1}};
            state_n  = DONE;
          end else begin
            state_n = ITER;
          end
        end else begin
          opnd_n  = a_abs;
          lo_n    = b_abs;
          state_n = ITER;
        end
      end
      ITER: begin
        if (step_en) begin
          if (is_div) begin
            hi_n = take ? alu_out : shifted[XLEN-1:0];
            lo_n = {acc_lo[XLEN-2:0], take};
          end else begin
            hi_n = {carry, alu_out[XLEN-1:1]};
            lo_n = {alu_out[0], acc_lo[XLEN-1:1]};
          end
          cnt_n = cnt - ITER_CNT_W'(1);
          if (cnt == ITER_CNT_W'(1)) state_n = FIX;
        end
      end
      FIX: begin
        if (is_div)              result_n = neg_res ? (XLEN'(0) - div_val) : div_val;
        else if (op_q == OP_MUL) result_n = prod_fix[XLEN-1:0];
        else                     result_n = prod_fix[PROD_W-1:XLEN];
        state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // ALU operands are registered from the next-cycle accumulator state
    if (state_n == ITER) begin
      if (op_n[2]) begin
        alu_a_n   = {hi_n[XLEN-2:0], lo_n[XLEN-1]};
        alu_b_n   = opnd_n;
        alu_ctl_n = ALU_SUB;
      end else begin
        alu_a_n   = hi_n;
        alu_b_n   = lo_n[0] ? opnd_n : '0;
        alu_ctl_n = ALU_ADD;
      end
    end
  end

  assign busy_n = (state_n == PREP) || (state_n == ITER) || (state_n == FIX);
  assign done_n = (state_n == DONE);

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed vectors for alu_muldiv_seq with a behavioural ADD/SUB ALU.
// Define MULDIV_ALU_SHARE_EN to also exercise the alu_grant stall path.
`timescale 1ns/1ps
module tb_alu_muldiv_seq;

  localparam logic [4:0] ALU_ADD = 5'b00001;
  localparam logic [4:0] ALU_SUB = 5'b01001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [31:0] alu_out;
  logic        alu_grant = 1'b1;
  logic        busy, done;
  logic [31:0] result, alu_a, alu_b;
  logic [4:0]  alu_ctl;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign alu_out = (alu_ctl == ALU_SUB) ? (alu_a - alu_b) : (alu_a + alu_b);

  alu_muldiv_seq #(.XLEN(32), .ITER_CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .alu_out(alu_out),
`ifdef MULDIV_ALU_SHARE_EN
    .alu_grant(alu_grant),
`endif
    .busy(busy), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op, then check latency, result, SUB-cycle count and the one-cycle done pulse
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input int exp_sub,
                        input bit toggle, input string tag);
    int cyc;
    int sub_cnt;
    @(posedge clk); #1;
    start = 1'b1; op = o; rs1 = a; rs2 = b; alu_grant = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    sub_cnt = 0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && cyc < 200) begin
      if (alu_ctl == ALU_SUB) sub_cnt++;
      if (toggle) alu_grant = (cyc >= 2 && cyc <= 33) ? (cyc % 2 == 0) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    alu_grant = 1'b1;
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_subcyc"}, 32'(sub_cnt), 32'(exp_sub));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_ctl_idle"}, 32'(alu_ctl), 32'(ALU_ADD));
  endtask

  int dones;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_ctl", 32'(alu_ctl), 32'(ALU_ADD));
    rst = 1'b0;

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 0, 1'b0, "mul_7_m3");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 0, 1'b0, "mulhu_ff");
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 35, 0, 1'b0, "mulh_ff");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, 0, 1'b0, "mulhsu_ff");
    run_op(3'b000, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 35, 0, 1'b0, "mul_lo");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 32, 1'b0, "div_m7_2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 32, 1'b0, "rem_m7_2");
    run_op(3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 35, 32, 1'b0, "divu_big");
    run_op(3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 35, 32, 1'b0, "remu_big");
    run_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 0, 1'b0, "divu_by0");
    run_op(3'b110, 32'd5, 32'd0, 32'd5, 2, 0, 1'b0, "rem_by0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35, 32, 1'b0, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 35, 32, 1'b0, "rem_ovf");
    run_op(3'b111, 32'd100, 32'd7, 32'd2, 35, 32, 1'b0, "remu_100_7");

    // Abort in ITER cycle 10 while result still holds the previous value
    @(posedge clk); #1;
    start = 1'b1; op = 3'b000; rs1 = 32'd5; rs2 = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_ctl", 32'(alu_ctl), 32'(ALU_ADD));
    #2;
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run_op(3'b000, 32'd3, 32'd4, 32'd12, 35, 0, 1'b0, "mul_3_4");

    // start held high for the whole operation starts only one op
    @(posedge clk); #1;
    start = 1'b1; op = 3'b011; rs1 = 32'h0001_0000; rs2 = 32'h0001_0000;
    dones = 0;
    for (int i = 0; i < 60 && dones == 0; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    start = 1'b0;
    check("hold_result", result, 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("hold_one_done", 32'(dones), 32'd1);
    check("hold_idle", 32'(busy), 32'd0);

`ifdef MULDIV_ALU_SHARE_EN
    run_op(3'b000, 32'd3, 32'd4, 32'd12, 51, 0, 1'b1, "mul_share");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Multi-cycle RV32M multiply/divide sequencer placed beside the core ALU. It accepts one MUL/DIV/REM operation and performs 32 shift-add or restoring-subtract iterations, using the 5-bit-coded ALU for each 32-bit add/subtract. Sign pre- and post-conditioning is done locally. The result returns to the execute stage with a done pulse.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
ITER_CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  op request; sampled only while busy=0
op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  in  32  dividend / multiplicand
rs2  in  32  divisor / multiplier
busy  out  1  high from the cycle after start acceptance until done
done  out  1  one-cycle pulse; result valid in the same cycle
result  out  32  final value; held until the next acceptance
alu_a  out  32  ALU operand A
alu_b  out  32  ALU operand B
alu_ctl  out  5  ALU op: 5'b00001 ADD, 5'b01001 SUB
alu_out  in  32  ALU combinational result
alu_grant  in  1  present only with MULDIV_ALU_SHARE_EN

Behaviour:
- Reset (async): state=IDLE; busy=0; done=0; result=0; alu_a=0; alu_b=0; alu_ctl=5'b00001; counter=0.
- FSM states: IDLE, PREP, ITER, FIX, DONE.
- IDLE: start=1 latches op, rs1 and rs2, then moves to PREP. start while busy=1 is ignored; no queueing.
- PREP (1 cycle):
  - Signed operands (MULH: both; MULHSU: rs1 only; DIV/REM: both) are replaced locally by their absolute value.
  - neg_res = sign(a)^sign(b) for MUL*; sign(dividend) for REM; sign(a)^sign(b) for DIV.
  - Divisor==0 on DIV*/REM*: go straight to DONE. Quotient = 32'hFFFF_FFFF; remainder = original rs1.
  - Otherwise: counter=32, go to ITER.
- ITER, multiply: acc_hi starts at 0, acc_lo = multiplier. alu_a=acc_hi; alu_b = acc_lo[0] ? mcand : 0; alu_ctl=ADD.
  - carry = (alu_out < acc_hi) unsigned.
  - {acc_hi,acc_lo} <= {carry, alu_out, acc_lo[31:1]} >> 0, i.e. a 65-bit value shifted right by 1.
- ITER, divide (restoring): rem starts at 0. Each cycle: shifted = {rem[31:0], q[31]} as 33 bits, q <<= 1.
  - alu_a = shifted[31:0]; alu_b = divisor; alu_ctl=SUB.
  - If shifted[32] or shifted[31:0] >= divisor: rem <= alu_out and q[0] <= 1. Otherwise rem <= shifted[31:0] and q[0] <= 0.
- Counter decrements each iteration; the last iteration (counter==1) goes to FIX.
- FIX (1 cycle): 64-bit negate of the product if neg_res (MUL*), or 32-bit negate of quotient/remainder. Selects the low word for MUL and the high word for MULH*. Writes result.
- DONE: done=1 for exactly one cycle, busy=0 that cycle, then IDLE. start in the DONE cycle is not accepted; it is accepted in the next IDLE cycle.
- Latency, start edge to done: 35 cycles (IDLE→PREP 1, ITER 32, FIX 1, DONE 1); divide-by-zero 2 cycles.
- Overflow: DIV 0x80000000 / -1 gives 0x80000000; REM of the same gives 0. No trap.
- Outside ITER: alu_a=0, alu_b=0, alu_ctl=ADD.
- Reset asserted mid-operation aborts immediately: no done, result returns to 0.

Optional Feature:
MULDIV_ALU_SHARE_EN.
- Defined: adds the alu_grant input; the ALU is shared with the pipeline.
  - An ITER step (state update and counter decrement) commits only in cycles with alu_grant=1. Otherwise all state holds and alu_a/alu_b/alu_ctl stay driven.
  - Latency = 35 + number of ungranted ITER cycles.
- Undefined: port absent; every ITER cycle commits.

Test Plan:
- MUL rs1=7, rs2=-3 → done at cycle 35, result=0xFFFF_FFEB; ALU observed at ADD throughout ITER.
- MULHU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFE; MULH same operands → 0; MULHSU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFF.
- DIV -7/2 → 0xFFFF_FFFD; REM -7/2 → 0xFFFF_FFFF; DIVU 0xFFFF_FFFF/0x8000_0001 → 1 with REMU 0x7FFF_FFFE (tests the shifted[32] path).
- DIVU 5/0 → 0xFFFF_FFFF within 2 cycles; REM 5/0 → 5; DIV 0x8000_0000/-1 → 0x8000_0000, REM → 0.
- Pulse rst at ITER cycle 10 → busy=0 and result=0 immediately, no done. A new MUL 3×4 then returns 12. start held high throughout the operation starts exactly one op.
- With MULDIV_ALU_SHARE_EN: alu_grant low on alternate ITER cycles for MUL 3×4 → result 12, done at cycle 35+16=51.
